// File: rtl/bus_cycle_stepper.sv
// Bus-cycle gate for the 68000 board: grants each CPU bus cycle through
// ENABLE_EXECUTE in free-run, single-step, N-cycle burst or
// run-until-breakpoint mode, with a synchronised and debounced STEP switch.
module bus_cycle_stepper #(
    parameter int unsigned DEBOUNCE_BITS = 12,
    parameter int unsigned COUNT_WIDTH   = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                   CPUCLK_IN,
    input  logic                   RUN_IN,
    input  logic [1:0]             MODE_IN,
    input  logic                   STEP_IN,
    input  logic [COUNT_WIDTH-1:0] BURST_COUNT_IN,
    input  logic                   BREAK_HIT_IN,
    input  logic                   ENABLE_IN,
    output logic                   ENABLE_EXECUTE,
    output logic                   PAUSED,
    output logic [COUNT_WIDTH-1:0] CREDIT_OUT,
    output logic                   BROKEN_OUT,
    output logic                   STEP_LEVEL_OUT
);

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_STEP  = 2'b01,
        MODE_BURST = 2'b10,
        MODE_BREAK = 2'b11
    } mode_t;

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0]   r_sync;
    logic [DEBOUNCE_BITS-1:0] r_db_cnt;
    logic                     r_fstep;
    logic                     r_fstep_d;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     r_en_exec;
    logic                     w_en_exec_nxt;
    logic [COUNT_WIDTH-1:0]   r_credit;
    logic [COUNT_WIDTH-1:0]   w_credit_nxt;
    logic                     r_broken;
    logic                     w_broken_nxt;

    mode_t                    w_mode;
    logic                     w_sstep;
    logic                     w_press;
    logic                     w_free;
    logic                     w_credit_zero;

    assign w_mode        = mode_t'(MODE_IN);
    assign w_sstep       = r_sync[SYNC_STAGES-1];
    assign w_press       = r_fstep & ~r_fstep_d;
    assign w_free        = (w_mode == MODE_RUN) | ((w_mode == MODE_BREAK) & ~r_broken);
    assign w_credit_zero = (r_credit == '0);

    // Synchroniser chain bringing the raw STEP switch into the clock domain
    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], STEP_IN};
        end
    end

    // Debouncer: level follows the synchronised switch only after it has
    // disagreed for 2^DEBOUNCE_BITS consecutive clocks
    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_db_cnt  <= '0;
            r_fstep   <= 1'b0;
            r_fstep_d <= 1'b0;
        end else begin
            r_fstep_d <= r_fstep;
            if (w_sstep == r_fstep) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == '1) begin
                r_fstep  <= ~r_fstep;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    // FSM, grant, credit and breakpoint registers
    always_ff @(posedge CPUCLK_IN or negedge RUN_IN) begin
        if (!RUN_IN) begin
            r_state   <= ST_WAIT;
            r_en_exec <= 1'b0;
            r_credit  <= '0;
            r_broken  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_en_exec <= w_en_exec_nxt;
            r_credit  <= w_credit_nxt;
            r_broken  <= w_broken_nxt;
        end
    end

    // Next-state logic: press handling first, then the grant FSM, whose
    // decrement can only fire with credit>0 and so never collides with a load
    always_comb begin
        w_state_nxt   = r_state;
        w_en_exec_nxt = r_en_exec;
        w_credit_nxt  = r_credit;
        w_broken_nxt  = r_broken;

        if (w_mode == MODE_RUN) begin
            w_credit_nxt = '0;
            w_broken_nxt = 1'b0;
        end else if (w_press && w_credit_zero) begin
            unique case (w_mode)
                MODE_STEP:  w_credit_nxt = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
                MODE_BURST: w_credit_nxt = BURST_COUNT_IN;
                MODE_BREAK: w_broken_nxt = 1'b0;
                default:    w_credit_nxt = r_credit;
            endcase
        end

        unique case (r_state)
            ST_WAIT: begin
                w_en_exec_nxt = 1'b0;
                if (ENABLE_IN && w_free) begin
                    w_en_exec_nxt = 1'b1;
                    w_state_nxt   = ST_EXEC;
                end else if (ENABLE_IN && !w_credit_zero) begin
                    w_en_exec_nxt = 1'b1;
                    w_credit_nxt  = r_credit - 1'b1;
                    w_state_nxt   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_mode == MODE_BREAK && BREAK_HIT_IN) begin
                    w_broken_nxt = 1'b1;
                end
                if (!ENABLE_IN) begin
                    w_en_exec_nxt = 1'b0;
                    w_state_nxt   = ST_WAIT;
                end
            end
            default: begin
                w_en_exec_nxt = 1'b0;
                w_state_nxt   = ST_WAIT;
            end
        endcase
    end

    assign ENABLE_EXECUTE = r_en_exec;
    assign CREDIT_OUT     = r_credit;
    assign BROKEN_OUT     = r_broken;
    assign STEP_LEVEL_OUT = r_fstep;
    assign PAUSED         = (r_state == ST_WAIT) & ~w_free & w_credit_zero;

endmodule

// File: tb/tb_bus_cycle_stepper.sv
// Scoreboard bench for bus_cycle_stepper: stimulus pushes the expected grant
// (cycle of rise, credit after grant, grant length) and a negedge monitor pops
// and compares on every ENABLE_EXECUTE rise and fall.
module tb_bus_cycle_stepper;

    localparam int unsigned CW = 8;

    logic          clk = 1'b0;
    logic          run_n = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          step = 1'b0;
    logic [CW-1:0] burst = '0;
    logic          brk = 1'b0;
    logic          en_in = 1'b0;
    logic          en_exec;
    logic          paused;
    logic [CW-1:0] credit;
    logic          broken;
    logic          step_lvl;

    bus_cycle_stepper #(
        .DEBOUNCE_BITS(4),
        .COUNT_WIDTH  (CW),
        .SYNC_STAGES  (2)
    ) dut (
        .CPUCLK_IN     (clk),
        .RUN_IN        (run_n),
        .MODE_IN       (mode),
        .STEP_IN       (step),
        .BURST_COUNT_IN(burst),
        .BREAK_HIT_IN  (brk),
        .ENABLE_IN     (en_in),
        .ENABLE_EXECUTE(en_exec),
        .PAUSED        (paused),
        .CREDIT_OUT    (credit),
        .BROKEN_OUT    (broken),
        .STEP_LEVEL_OUT(step_lvl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int credit;
        int len;
    } grant_t;

    grant_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic expect_grant(input int c, input int cr, input int len);
        grant_t g;
        g.cyc = c;
        g.credit = cr;
        g.len = len;
        sb.push_back(g);
    endtask

    // Granted pulse: ENABLE_IN high for len clocks, expected rise next clock
    task automatic grant_pulse(input int len, input int cr);
        expect_grant(cyc + 1, cr, len);
        en_in = 1'b1;
        tick(len);
        en_in = 1'b0;
        tick(3);
    endtask

    // Pulse that must stall (no expectation pushed)
    task automatic stall_pulse();
        en_in = 1'b1;
        tick(4);
        en_in = 1'b0;
        tick(3);
    endtask

    // Granted pulse in mode 11 carrying a breakpoint hit while in EXEC
    task automatic break_pulse(input int cr);
        expect_grant(cyc + 1, cr, 2);
        en_in = 1'b1;
        tick(1);
        brk = 1'b1;
        tick(1);
        brk = 1'b0;
        en_in = 1'b0;
        tick(3);
    endtask

    task automatic press_release();
        step = 1'b1;
        tick(25);
        step = 1'b0;
        tick(25);
    endtask

    // Monitor
    logic   prev_en = 1'b0;
    int     run_len = 0;
    bit     have_cur = 0;
    grant_t cur;

    always @(negedge clk or negedge en_exec) begin
        if (en_exec && !prev_en) begin
            run_len = 1;
            if (sb.size() == 0) begin
                total++;
                bad++;
                have_cur = 0;
                $display("FAIL unexpected_grant: got grant at cycle %0d expected none", cyc);
            end else begin
                cur = sb.pop_front();
                have_cur = 1;
                chk("grant_cycle", cyc, cur.cyc);
                chk("grant_credit", credit, cur.credit);
            end
        end else if (en_exec) begin
            run_len++;
        end else if (prev_en && have_cur) begin
            chk("grant_length", run_len, cur.len);
            have_cur = 0;
        end
        prev_en = en_exec;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int k;
    int c;

    initial begin
        // Reset state
        tick(3);
        chk("rst_en_exec", en_exec, 0);
        chk("rst_credit", credit, 0);
        chk("rst_broken", broken, 0);
        chk("rst_step_level", step_lvl, 0);
        chk("rst_paused_mode00", paused, 0);
        run_n = 1'b1;
        tick(2);

        // Mode 00: free-run, 10-clock cycle
        mode = 2'b00;
        expect_grant(cyc + 1, 0, 10);
        en_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("run_paused", paused, 0);
        end
        en_in = 1'b0;
        chk("run_en_before_fall", en_exec, 1);
        tick(1);
        chk("run_en_after_fall", en_exec, 0);
        tick(3);

        // Mode 01: bouncing switch then stable high, ENABLE_IN held
        mode = 2'b01;
        tick(2);
        chk("step_paused_idle", paused, 1);
        en_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step = (i % 2 == 0);
            tick(3);
        end
        step = 1'b1;
        k = cyc;
        expect_grant(k + 20, 0, 6);
        wait_until(k + 25);
        en_in = 1'b0;
        tick(3);
        stall_pulse();
        stall_pulse();
        wait_until(k + 200);
        chk("step_held_level", step_lvl, 1);
        chk("step_paused_after", paused, 1);
        chk("step_credit_after", credit, 0);
        step = 1'b0;
        tick(25);
        chk("step_released_level", step_lvl, 0);

        // Mode 10: burst of 3, then burst of 0
        mode = 2'b10;
        burst = 8'd3;
        step = 1'b1;
        tick(25);
        chk("burst_credit_loaded", credit, 3);
        chk("burst_paused_loaded", paused, 0);
        step = 1'b0;
        tick(25);
        grant_pulse(2, 2);
        grant_pulse(2, 1);
        grant_pulse(2, 0);
        stall_pulse();
        stall_pulse();
        chk("burst_credit_empty", credit, 0);
        chk("burst_paused_empty", paused, 1);
        burst = 8'd0;
        press_release();
        chk("burst0_credit", credit, 0);
        stall_pulse();

        // Mode 11: break on second cycle, press resumes free-run
        mode = 2'b11;
        tick(1);
        chk("break_paused_free", paused, 0);
        grant_pulse(2, 0);
        break_pulse(0);
        chk("break_broken_set", broken, 1);
        chk("break_paused_set", paused, 1);
        en_in = 1'b1;
        tick(5);
        step = 1'b1;
        k = cyc;
        expect_grant(k + 20, 0, 3);
        wait_until(k + 22);
        en_in = 1'b0;
        tick(3);
        chk("break_broken_cleared", broken, 0);
        step = 1'b0;
        tick(25);
        grant_pulse(2, 0);
        chk("break_paused_resumed", paused, 0);

        // Mode switch 10->00 in WAIT with credit 2, then 00->01 in EXEC
        mode = 2'b10;
        burst = 8'd2;
        step = 1'b1;
        tick(25);
        chk("switch_credit_loaded", credit, 2);
        step = 1'b0;
        tick(25);
        c = cyc;
        mode = 2'b00;
        en_in = 1'b1;
        expect_grant(c + 1, 0, 4);
        tick(1);
        chk("switch_credit_cleared", credit, 0);
        tick(1);
        mode = 2'b01;
        tick(2);
        en_in = 1'b0;
        tick(3);
        stall_pulse();
        chk("switch_paused_step", paused, 1);

        // Reset mid-EXEC with credit and BROKEN set
        mode = 2'b11;
        tick(1);
        break_pulse(0);
        mode = 2'b10;
        burst = 8'd3;
        step = 1'b1;
        tick(25);
        chk("rstx_credit_loaded", credit, 3);
        chk("rstx_broken_kept", broken, 1);
        step = 1'b0;
        tick(25);
        c = cyc;
        expect_grant(c + 1, 2, 2);
        en_in = 1'b1;
        tick(3);
        run_n = 1'b0;
        #1;
        chk("rstx_en_async", en_exec, 0);
        chk("rstx_credit", credit, 0);
        chk("rstx_broken", broken, 0);
        mode = 2'b00;
        tick(2);
        run_n = 1'b1;
        c = cyc;
        expect_grant(c + 1, 0, 3);
        wait_until(c + 3);
        en_in = 1'b0;
        tick(5);

        chk("scoreboard_drained", sb.size() + (have_cur ? 1 : 0), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
